// File: rtl/timer_avm_pkg.sv
// Shared definitions for the interval-timer Avalon-MM initiator:
// slave register map, control/status bit positions and the FSM state type.
package timer_avm_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STATUS_TO  = 0;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_CTRL   = 4'd1,
        ST_WR_STATUS = 4'd2,
        ST_GUARD     = 4'd3,
        ST_WR_SNAP   = 4'd4,
        ST_RD_SNAPL  = 4'd5,
        ST_CAP_SNAPL = 4'd6,
        ST_RD_SNAPH  = 4'd7,
        ST_CAP_SNAPH = 4'd8,
        ST_POLL_RD   = 4'd9,
        ST_POLL_CAP  = 4'd10
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_poll_counter.sv
// Status-poll interval timer: down-counter that reloads while disabled
// and pulses o_expire for one cycle each time it reaches zero.
module timer_poll_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_reload,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    assign o_expire = i_en && (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_en || o_expire) begin
            r_count <= i_reload;
        end else begin
            r_count <= r_count - W'(1);
        end
    end

endmodule

// File: rtl/timer_avalon_master.sv
// Avalon-MM initiator that starts/stops the interval timer, services its
// timeouts by irq or polling, and reads back the counter snapshot.
//   state      | meaning
//   IDLE       | arbitrate stop > start > timeout > snap > poll
//   WR_CTRL    | write CONTROL (start or stop word)
//   WR_STATUS  | clear TO flag, emit tick
//   GUARD      | let slave irq fall before re-arbitrating
//   WR_SNAP    | latch counter into SNAPL/SNAPH
//   RD_/CAP_SNAPL, RD_/CAP_SNAPH | read and capture snapshot halves
//   POLL_RD/POLL_CAP | read STATUS and test TO
module timer_avalon_master
    import timer_avm_pkg::*;
#(
    parameter int TICK_W        = 16,
    parameter int POLL_INTERVAL = 1024,
    parameter bit SNAP_ON_TICK  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_continuous,
    input  logic              cfg_irq_en,
    input  logic              snap_req,
    input  logic              irq,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snap_valid,
    output logic              running,
    output logic              busy
);

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_pend;
    logic                r_stop_pend;
    logic                r_snap_pend;
    logic                r_cont;
    logic [15:0]         r_ctrl_word;
    logic                r_running;
    logic [TICK_W-1:0]   r_tick_count;
    logic [31:0]         r_snap;
    logic                r_poll_due;
    logic                w_idle;
    logic                w_poll_en;
    logic                w_poll_expire;
    logic                w_take_ctrl;
    logic                w_take_poll;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_poll_en   = !cfg_irq_en && r_running;
    assign w_take_ctrl = w_idle && (w_state_nxt == ST_WR_CTRL);
    assign w_take_poll = w_idle && (w_state_nxt == ST_POLL_RD);

    timer_poll_counter #(.W(16)) u_poll (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_poll_en),
        .i_reload (POLL_RELOAD),
        .o_expire (w_poll_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_stop_pend || r_start_pend) begin
                    w_state_nxt = ST_WR_CTRL;
                end else if (cfg_irq_en && irq) begin
                    w_state_nxt = ST_WR_STATUS;
                end else if (r_snap_pend) begin
                    w_state_nxt = ST_WR_SNAP;
                end else if (r_poll_due && w_poll_en) begin
                    w_state_nxt = ST_POLL_RD;
                end
            end
            ST_WR_CTRL:   w_state_nxt = ST_IDLE;
            ST_WR_STATUS: w_state_nxt = ST_GUARD;
            ST_GUARD:     w_state_nxt = SNAP_ON_TICK ? ST_WR_SNAP : ST_IDLE;
            ST_WR_SNAP:   w_state_nxt = ST_RD_SNAPL;
            ST_RD_SNAPL:  w_state_nxt = ST_CAP_SNAPL;
            ST_CAP_SNAPL: w_state_nxt = ST_RD_SNAPH;
            ST_RD_SNAPH:  w_state_nxt = ST_CAP_SNAPH;
            ST_CAP_SNAPH: w_state_nxt = ST_IDLE;
            ST_POLL_RD:   w_state_nxt = ST_POLL_CAP;
            ST_POLL_CAP:  w_state_nxt = avm_readdata[STATUS_TO] ? ST_WR_STATUS : ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        avm_address    = ADDR_STATUS;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        case (r_state)
            ST_WR_CTRL: begin
                avm_address    = ADDR_CONTROL;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = r_ctrl_word;
            end
            ST_WR_STATUS: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
            end
            ST_WR_SNAP: begin
                avm_address    = ADDR_SNAPL;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
            end
            ST_RD_SNAPL: begin
                avm_address    = ADDR_SNAPL;
                avm_chipselect = 1'b1;
            end
            ST_RD_SNAPH: begin
                avm_address    = ADDR_SNAPH;
                avm_chipselect = 1'b1;
            end
            ST_POLL_RD: begin
                avm_chipselect = 1'b1;
            end
            default: ;
        endcase
    end

    // Stop beats a simultaneous start; a fresh pulse always outranks clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_pend <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_cont       <= 1'b0;
            r_ctrl_word  <= '0;
            r_running    <= 1'b0;
            r_tick_count <= '0;
            r_snap       <= '0;
            r_poll_due   <= 1'b0;
        end else begin
            if (cfg_stop) begin
                r_stop_pend <= 1'b1;
            end else if (w_take_ctrl && r_stop_pend) begin
                r_stop_pend <= 1'b0;
            end

            if (cfg_start && cfg_stop) begin
                r_start_pend <= 1'b0;
            end else if (cfg_start) begin
                r_start_pend <= 1'b1;
                r_cont       <= cfg_continuous;
            end else if (w_take_ctrl && !r_stop_pend) begin
                r_start_pend <= 1'b0;
            end

            if (w_take_ctrl) begin
                r_ctrl_word <= r_stop_pend ? ctrl_word(1'b1, 1'b0, 1'b0, 1'b0)
                                           : ctrl_word(1'b0, 1'b1, r_cont, cfg_irq_en);
            end

            if (r_state == ST_WR_CTRL) begin
                r_running <= !r_ctrl_word[CTRL_STOP];
            end

            if (snap_req) begin
                r_snap_pend <= 1'b1;
            end else if (r_state == ST_CAP_SNAPH) begin
                r_snap_pend <= 1'b0;
            end

            if (r_state == ST_WR_STATUS) begin
                r_tick_count <= r_tick_count + TICK_W'(1);
            end

            if (r_state == ST_CAP_SNAPL) begin
                r_snap[15:0] <= avm_readdata;
            end
            if (r_state == ST_CAP_SNAPH) begin
                r_snap[31:16] <= avm_readdata;
            end

            if (!w_poll_en) begin
                r_poll_due <= 1'b0;
            end else if (w_poll_expire) begin
                r_poll_due <= 1'b1;
            end else if (w_take_poll) begin
                r_poll_due <= 1'b0;
            end
        end
    end

    // Forward the high half during CAP_SNAPH so snapshot is complete when snap_valid pulses.
    assign snapshot   = (r_state == ST_CAP_SNAPH) ? {avm_readdata, r_snap[15:0]} : r_snap;
    assign snap_valid = (r_state == ST_CAP_SNAPH);
    assign tick       = (r_state == ST_WR_STATUS);
    assign tick_count = r_tick_count;
    assign running    = r_running;
    assign busy       = !w_idle;

endmodule

// File: tb/tb_timer_avalon_master.sv
// Bench for timer_avalon_master: behavioural timer slave, bus transaction
// monitor and a transaction-level expectation of every service sequence.
module tb_timer_avalon_master;

    localparam int PI = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_stop, cfg_continuous, cfg_irq_en, snap_req;
    logic        irq;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snapshot;
    logic        snap_valid, running, busy;

    always #5 clk = ~clk;

    timer_avalon_master #(.TICK_W(16), .POLL_INTERVAL(PI), .SNAP_ON_TICK(1'b1)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_continuous(cfg_continuous), .cfg_irq_en(cfg_irq_en), .snap_req(snap_req),
        .irq(irq), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .tick(tick), .tick_count(tick_count), .snapshot(snapshot), .snap_valid(snap_valid),
        .running(running), .busy(busy));

    // Timer slave: one TO flag, control register, snapshot latch, registered readdata.
    logic [15:0] s_ctrl;
    logic        s_to;
    logic [31:0] s_snap_lat;
    logic [31:0] snap_src;
    logic        s_fire;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ctrl <= '0; s_to <= 1'b0; s_snap_lat <= '0; avm_readdata <= '0;
        end else begin
            if (s_fire) s_to <= 1'b1;
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: s_ctrl <= avm_writedata;
                    3'd4: s_snap_lat <= snap_src;
                    default: ;
                endcase
            end
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    3'd0: avm_readdata <= {14'd0, s_ctrl[2], s_to};
                    3'd4: avm_readdata <= s_snap_lat[15:0];
                    3'd5: avm_readdata <= s_snap_lat[31:16];
                    default: avm_readdata <= '0;
                endcase
            end
        end
    end
    assign irq = s_to & s_ctrl[0];

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        tk;
        logic [31:0] cyc;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] snapq[$];
    logic [31:0] cyc = 0;
    int          n_ticks = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && avm_chipselect)
            txq.push_back('{wr: !avm_write_n, addr: avm_address, data: avm_writedata, tk: tick, cyc: cyc});
        if (!reset && snap_valid) snapq.push_back(snapshot);
        if (!reset && tick) n_ticks = n_ticks + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic get_txn(output txn_t t, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        t = '0;
        while (txq.size() == 0 && n < 60) begin
            wait_cyc(1);
            n++;
        end
        if (txq.size() != 0) begin
            t = txq.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic expect_txn(input string tag, input logic wr, input logic [2:0] addr,
                              input logic chkdata, input logic [15:0] data, output txn_t t);
        bit ok;
        get_txn(t, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_kind"}, {28'd0, t.wr, t.addr}, {28'd0, wr, addr});
            if (chkdata) check({tag, "_data"}, 32'(t.data), 32'(data));
        end
    endtask

    task automatic expect_snap_seq(input string tag, input logic [31:0] val);
        txn_t t;
        expect_txn({tag, "_wsnap"}, 1'b1, 3'd4, 1'b0, 16'h0, t);
        expect_txn({tag, "_rdl"},   1'b0, 3'd4, 1'b0, 16'h0, t);
        expect_txn({tag, "_rdh"},   1'b0, 3'd5, 1'b0, 16'h0, t);
        wait_cyc(1);
        check({tag, "_snapq_n"}, 32'(snapq.size()), 32'd1);
        if (snapq.size() != 0) check({tag, "_snapv"}, snapq.pop_front(), val);
        check({tag, "_snapshot"}, snapshot, val);
    endtask

    initial begin
        txn_t        t;
        txn_t        tprev;
        int          exp_ticks;
        int          n;
        bit          kind;
        logic [31:0] v;

        exp_ticks = 0;
        reset = 1'b1;
        cfg_start = 0; cfg_stop = 0; cfg_continuous = 0; cfg_irq_en = 0; snap_req = 0;
        s_fire = 0; snap_src = '0;
        wait_cyc(3);
        check("rst_cs", 32'(avm_chipselect), 0);
        check("rst_wn", 32'(avm_write_n), 1);
        check("rst_addr", 32'(avm_address), 0);
        check("rst_wdata", 32'(avm_writedata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_running", 32'(running), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_tcount", 32'(tick_count), 0);
        check("rst_snap", snapshot, 0);
        check("rst_svalid", 32'(snap_valid), 0);
        reset = 1'b0;
        wait_cyc(2);

        // Start in irq mode, continuous; CONT must be the value at the pulse.
        cfg_irq_en = 1; cfg_continuous = 1; cfg_start = 1;
        wait_cyc(1);
        cfg_start = 0; cfg_continuous = 0;
        expect_txn("start", 1'b1, 3'd1, 1'b1, 16'h0007, t);
        check("start_run_during", 32'(running), 0);
        wait_cyc(1);
        check("start_run_after", 32'(running), 1);
        wait_cyc(6);
        check("start_single", 32'(txq.size()), 0);

        // Directed irq timeout with snapshot.
        snap_src = 32'h0123_4567;
        s_fire = 1; exp_ticks++;
        wait_cyc(1);
        s_fire = 0;
        expect_txn("irq_clr", 1'b1, 3'd0, 1'b1, 16'h0000, t);
        check("irq_clr_tick", 32'(t.tk), 1);
        expect_snap_seq("irq", 32'h0123_4567);
        wait_cyc(10);
        check("irq_no_double", 32'(txq.size()), 0);
        check("irq_ticks", 32'(n_ticks), 32'(exp_ticks));
        check("irq_tcount", 32'(tick_count), 32'(exp_ticks));

        // Randomised mix of irq timeouts and one-off snapshot requests.
        for (int i = 0; i < 10; i++) begin
            kind = 1'($urandom_range(0, 1));
            v = $urandom;
            wait_cyc($urandom_range(2, 12));
            snap_src = v;
            if (kind) begin
                s_fire = 1; exp_ticks++;
            end else begin
                snap_req = 1;
            end
            wait_cyc(1);
            s_fire = 0; snap_req = 0;
            if (kind) expect_txn("rnd_clr", 1'b1, 3'd0, 1'b1, 16'h0000, t);
            expect_snap_seq("rnd", v);
            wait_cyc(4);
            check("rnd_idle", 32'(txq.size()), 0);
            check("rnd_tcount", 32'(tick_count), 32'(exp_ticks));
        end
        check("rnd_ticks", 32'(n_ticks), 32'(exp_ticks));

        // Start and stop together while busy: the stop alone is written afterwards.
        snap_src = 32'hCAFE_F00D;
        snap_req = 1;
        wait_cyc(1);
        snap_req = 0;
        n = 0;
        while (!busy && n < 20) begin
            wait_cyc(1);
            n++;
        end
        check("ss_busy", 32'(busy), 1);
        cfg_start = 1; cfg_stop = 1;
        wait_cyc(1);
        cfg_start = 0; cfg_stop = 0;
        expect_snap_seq("ss", 32'hCAFE_F00D);
        expect_txn("ss_stop", 1'b1, 3'd1, 1'b1, 16'h0008, t);
        wait_cyc(1);
        check("ss_running", 32'(running), 0);
        wait_cyc(12);
        check("ss_quiet", 32'(txq.size()), 0);

        // Polling mode: status read every PI cycles, then service on TO=1.
        cfg_irq_en = 0; cfg_continuous = 1; cfg_start = 1;
        wait_cyc(1);
        cfg_start = 0;
        expect_txn("pstart", 1'b1, 3'd1, 1'b1, 16'h0006, t);
        expect_txn("poll0", 1'b0, 3'd0, 1'b0, 16'h0, tprev);
        for (int i = 0; i < 2; i++) begin
            expect_txn("pollN", 1'b0, 3'd0, 1'b0, 16'h0, t);
            check("poll_period", t.cyc - tprev.cyc, 32'(PI));
            tprev = t;
        end
        snap_src = $urandom;
        v = snap_src;
        s_fire = 1; exp_ticks++;
        wait_cyc(1);
        s_fire = 0;
        expect_txn("poll_hit", 1'b0, 3'd0, 1'b0, 16'h0, t);
        check("poll_hit_period", t.cyc - tprev.cyc, 32'(PI));
        tprev = t;
        expect_txn("poll_clr", 1'b1, 3'd0, 1'b1, 16'h0000, t);
        check("poll_clr_lat", t.cyc - tprev.cyc, 32'd2);
        check("poll_clr_tick", 32'(t.tk), 1);
        expect_snap_seq("poll", v);
        check("poll_tcount", 32'(tick_count), 32'(exp_ticks));
        check("poll_ticks", 32'(n_ticks), 32'(exp_ticks));

        // Reset in the middle of WR_SNAP.
        snap_req = 1;
        wait_cyc(1);
        snap_req = 0;
        n = 0;
        while (!(avm_chipselect && !avm_write_n && avm_address == 3'd4) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_found", 32'(avm_chipselect && !avm_write_n && avm_address == 3'd4), 1);
        #1 reset = 1'b1;
        #1;
        check("mid_cs", 32'(avm_chipselect), 0);
        check("mid_wn", 32'(avm_write_n), 1);
        check("mid_addr", 32'(avm_address), 0);
        check("mid_wdata", 32'(avm_writedata), 0);
        check("mid_snap", snapshot, 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_running", 32'(running), 0);
        check("mid_tcount", 32'(tick_count), 0);
        wait_cyc(1);
        reset = 1'b0;
        txq.delete();
        snapq.delete();
        wait_cyc(1);
        check("post_busy", 32'(busy), 0);
        check("post_cs", 32'(avm_chipselect), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
